// File: rtl/keypad_pkg.sv
// Shared types and one-hot helpers for the keypad matrix scanner.
package keypad_pkg;

  typedef enum logic [1:0] {
    SCAN       = 2'd0,
    PRESS_DB   = 2'd1,
    HELD       = 2'd2,
    RELEASE_DB = 2'd3
  } scan_state_t;

  // Widest row/column vector supported; narrower vectors are zero-extended.
  localparam int MAX_LINES = 16;

  function automatic logic is_onehot(input logic [MAX_LINES-1:0] v);
    return ($countones(v) == 1);
  endfunction

  function automatic logic [3:0] onehot_index(input logic [MAX_LINES-1:0] v);
    logic [3:0] idx;
    idx = '0;
    for (int i = 0; i < MAX_LINES; i++)
      if (v[i]) idx = 4'(i);
    return idx;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a bus of independent asynchronous levels.
module sync_2ff #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge clk) begin
    if (reset) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/keypad_matrix_scanner.sv
// Row-scanning keypad reader: debounced single-key detection, one key per
// press (no auto-repeat), with a one-deep output register and overrun flag.
module keypad_matrix_scanner
  import keypad_pkg::*;
#(
  parameter int ROWS     = 4,
  parameter int COLS     = 4,
  parameter int SCAN_DIV = 48000,
  parameter int DEBOUNCE = 480000
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [COLS-1:0]          col,
  output logic [ROWS-1:0]          row_drive,
  output logic [$clog2(ROWS)-1:0]  key_row,
  output logic [$clog2(COLS)-1:0]  key_col,
  output logic                     key_valid,
  input  logic                     key_ready,
  output logic                     overrun,
  output logic                     busy
);

  localparam int RW = $clog2(ROWS);
  localparam int CW = $clog2(COLS);
  localparam int DW = $clog2(SCAN_DIV);
  localparam int BW = $clog2(DEBOUNCE + 1);
  localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);
  localparam logic [BW-1:0] DB_LAST    = BW'(DEBOUNCE - 1);

  scan_state_t     state;
  logic [COLS-1:0] col_s;
  logic [COLS-1:0] pattern;
  logic [DW-1:0]   dwell;
  logic [BW-1:0]   db_cnt;
  logic            press_ok;
  logic            confirm;
  logic [ROWS-1:0] row_next;
  logic [RW-1:0]   row_idx;
  logic [CW-1:0]   col_idx;

  sync_2ff #(.WIDTH(COLS)) u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (col),
    .q     (col_s)
  );

  // row_drive itself is the row register; its index is only needed for key_row.
  assign press_ok = is_onehot(MAX_LINES'(col_s));
  assign row_next = {row_drive[ROWS-2:0], row_drive[ROWS-1]};
  assign row_idx  = RW'(onehot_index(MAX_LINES'(row_drive)));
  assign col_idx  = CW'(onehot_index(MAX_LINES'(pattern)));
  assign confirm  = (state == PRESS_DB) && (col_s == pattern) && (db_cnt == DB_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= SCAN;
      row_drive <= ROWS'(1);
      dwell     <= '0;
      db_cnt    <= '0;
      pattern   <= '0;
      key_valid <= 1'b0;
      key_row   <= '0;
      key_col   <= '0;
      overrun   <= 1'b0;
      busy      <= 1'b0;
    end else begin
      overrun <= 1'b0;
      // A key accepted this cycle frees the register for a same-cycle confirm.
      if (confirm) begin
        if (!key_valid || key_ready) begin
          key_valid <= 1'b1;
          key_row   <= row_idx;
          key_col   <= col_idx;
        end else begin
          overrun <= 1'b1;
        end
      end else if (key_valid && key_ready) begin
        key_valid <= 1'b0;
      end

      case (state)
        SCAN: begin
          if (dwell == DWELL_LAST) begin
            dwell <= '0;
            if (press_ok) begin
              state   <= PRESS_DB;
              busy    <= 1'b1;
              pattern <= col_s;
              db_cnt  <= '0;
            end else begin
              row_drive <= row_next;
            end
          end else begin
            dwell <= dwell + DW'(1);
          end
        end
        PRESS_DB: begin
          if (col_s == pattern) begin
            db_cnt <= db_cnt + BW'(1);
            if (db_cnt == DB_LAST) state <= HELD;
          end else begin
            state     <= SCAN;
            busy      <= 1'b0;
            row_drive <= row_next;
            dwell     <= '0;
          end
        end
        HELD: begin
          if (col_s == '0) begin
            state  <= RELEASE_DB;
            db_cnt <= '0;
          end
        end
        RELEASE_DB: begin
          if (col_s == '0) begin
            if (db_cnt == DB_LAST) begin
              state     <= SCAN;
              busy      <= 1'b0;
              row_drive <= row_next;
              dwell     <= '0;
            end else begin
              db_cnt <= db_cnt + BW'(1);
            end
          end else begin
            state <= HELD;
          end
        end
        default: begin
          state <= SCAN;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_keypad_matrix_scanner.sv
// Directed scenarios plus random key/ready traffic against a behavioural keypad model.
module tb_keypad_matrix_scanner;

  localparam int R  = 4;
  localparam int C  = 4;
  localparam int SD = 4;
  localparam int DB = 3;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] col = '0;
  logic       key_ready = 1'b1;
  logic [3:0] row_drive;
  logic [1:0] key_row;
  logic [1:0] key_col;
  logic       key_valid;
  logic       overrun;
  logic       busy;

  int pass_cnt = 0;
  int total_cnt = 0;
  int ovr_seen = 0;

  // Model: scanning phase 0=scanning, 1=confirming, 2=held, 3=releasing.
  int m_row = 0, m_dw = 0, m_ph = 0, m_pat = 0, m_db = 0;
  int m_kr = 0, m_kc = 0, m_s1 = 0, m_s2 = 0;
  bit m_kv = 0, m_ovr = 0;

  keypad_matrix_scanner #(.ROWS(R), .COLS(C), .SCAN_DIV(SD), .DEBOUNCE(DB)) dut (
    .clk       (clk),
    .reset     (reset),
    .col       (col),
    .row_drive (row_drive),
    .key_row   (key_row),
    .key_col   (key_col),
    .key_valid (key_valid),
    .key_ready (key_ready),
    .overrun   (overrun),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    assert (act === exp) pass_cnt++;
    else $error("FAIL %s: got %0h expected %0h", tag, act, exp);
  endtask

  function automatic int bit_pos(input int v);
    int p;
    p = 0;
    for (int i = 0; i < C; i++) if (v[i]) p = i;
    return p;
  endfunction

  task automatic model_step();
    int  cs;
    bit  fire;
    if (reset) begin
      m_row = 0; m_dw = 0; m_ph = 0; m_pat = 0; m_db = 0;
      m_kv = 0; m_kr = 0; m_kc = 0; m_ovr = 0; m_s1 = 0; m_s2 = 0;
    end else begin
      cs = m_s2;
      fire = 0;
      m_ovr = 0;
      case (m_ph)
        0: if (m_dw == SD - 1) begin
             m_dw = 0;
             if ($countones(cs) == 1) begin m_ph = 1; m_pat = cs; m_db = 0; end
             else m_row = (m_row + 1) % R;
           end else m_dw++;
        1: if (cs == m_pat) begin
             m_db++;
             if (m_db == DB) begin fire = 1; m_ph = 2; end
           end else begin m_ph = 0; m_row = (m_row + 1) % R; m_dw = 0; end
        2: if (cs == 0) begin m_ph = 3; m_db = 0; end
        default: if (cs == 0) begin
             m_db++;
             if (m_db == DB) begin m_ph = 0; m_row = (m_row + 1) % R; m_dw = 0; end
           end else m_ph = 2;
      endcase
      if (fire) begin
        if (!m_kv || key_ready) begin m_kv = 1; m_kr = m_row; m_kc = bit_pos(m_pat); end
        else m_ovr = 1;
      end else if (m_kv && key_ready) m_kv = 0;
      m_s2 = m_s1;
      m_s1 = int'(col);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    model_step();
    @(negedge clk);
    chk("row_drive", row_drive, 32'(1) << m_row);
    chk("key_valid", key_valid, m_kv);
    chk("busy", busy, (m_ph != 0));
    chk("overrun", overrun, m_ovr);
    if (m_kv) begin
      chk("key_row", key_row, m_kr);
      chk("key_col", key_col, m_kc);
    end
    if (overrun === 1'b1) ovr_seen++;
  endtask

  // Wait for the start of a dwell on row r (row changes only on a dwell boundary).
  task automatic wait_row(input int r);
    int n;
    n = 0;
    while (row_drive === 4'(1 << r) && n < 64) begin cyc(); n++; end
    while (row_drive !== 4'(1 << r) && n < 64) begin cyc(); n++; end
    chk("wait_row_timeout", row_drive, 32'(1) << r);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy !== 1'b0 && n < 64) begin cyc(); n++; end
    chk("wait_idle_timeout", busy, 0);
  endtask

  task automatic press_key(input int r, input logic [3:0] pat, input int hold);
    wait_row(r);
    col = pat;
    repeat (hold) cyc();
    col = '0;
    wait_idle();
  endtask

  initial begin
    // Reset state
    reset = 1'b1;
    cyc();
    chk("rst_row_drive", row_drive, 1);
    chk("rst_key_valid", key_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_overrun", overrun, 0);
    chk("rst_key_row", key_row, 0);
    chk("rst_key_col", key_col, 0);
    reset = 1'b0;

    // Idle scanning: each row for SD cycles, wrapping
    for (int k = 1; k <= 32; k++) begin
      cyc();
      chk("idle_scan_row", row_drive, 32'(1) << ((k / SD) % R));
      chk("idle_no_key", key_valid, 0);
    end

    // Single key on row 2, column 2, consumer always ready
    wait_row(2);
    col = 4'b0100;
    repeat (7) cyc();
    chk("press_valid", key_valid, 1);
    chk("press_row", key_row, 2);
    chk("press_col", key_col, 2);
    chk("press_busy", busy, 1);
    cyc();
    chk("press_valid_cleared", key_valid, 0);
    chk("press_busy_held", busy, 1);
    col = '0;
    wait_idle();
    chk("release_next_row", row_drive, 4'b1000);

    // Press lost during debounce: back to scanning at the next row
    wait_row(2);
    col = 4'b0100;
    repeat (4) cyc();
    chk("glitch_debouncing", busy, 1);
    col = '0;
    repeat (3) cyc();
    chk("glitch_no_key", key_valid, 0);
    chk("glitch_idle", busy, 0);
    chk("glitch_row3", row_drive, 4'b1000);

    // Two columns at once is not a press
    wait_row(1);
    col = 4'b0110;
    repeat (4) cyc();
    chk("multi_idle", busy, 0);
    chk("multi_advanced", row_drive, 4'b0100);
    col = '0;
    repeat (4) cyc();
    chk("multi_no_key", key_valid, 0);

    // Consumer stalled: second key dropped with a single overrun pulse
    key_ready = 1'b0;
    press_key(0, 4'b0001, 10);
    chk("stall_first_valid", key_valid, 1);
    ovr_seen = 0;
    press_key(3, 4'b1000, 10);
    chk("stall_overrun_once", ovr_seen, 1);
    chk("stall_valid_kept", key_valid, 1);
    chk("stall_row_kept", key_row, 0);
    chk("stall_col_kept", key_col, 0);

    // Reset while a key is held and one is pending
    wait_row(1);
    col = 4'b0010;
    repeat (9) cyc();
    chk("pre_reset_busy", busy, 1);
    chk("pre_reset_valid", key_valid, 1);
    reset = 1'b1;
    cyc();
    chk("mid_rst_row_drive", row_drive, 1);
    chk("mid_rst_valid", key_valid, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_overrun", overrun, 0);
    col = '0;
    reset = 1'b0;
    key_ready = 1'b1;

    // Random key activity and consumer back-pressure
    for (int n = 0; n < 120; n++) begin
      int sel;
      int len;
      sel = $urandom_range(0, 9);
      len = $urandom_range(1, 16);
      if (sel < 4) col = '0;
      else if (sel < 8) col = 4'(1 << $urandom_range(0, 3));
      else col = 4'($urandom_range(0, 15));
      for (int j = 0; j < len; j++) begin
        key_ready = ($urandom_range(0, 3) != 0);
        cyc();
      end
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
